// File: rtl/ps_tx_scheduler.sv
// Byte scheduler in front of the PHY serializer: a fixed alignment phase after reset,
// then burst-limited round-robin sharing of the serializer between two byte lanes.
module ps_tx_scheduler #(
    parameter int          SYNC_LEN  = 4,
    parameter int          MAX_BURST = 8,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       sync_done
);

    localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SERVE0 = 2'd2,
        ST_SERVE1 = 2'd3
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   sync_cnt_q;
    logic [CW-1:0]   cnt_q;
    logic            last_q;
    logic [7:0]      data_out_q;
    logic            valid_out_q;
    logic [1:0]      grant_q;
    logic            sync_done_q;

    logic [1:0]      req_v;
    logic [1:0]      serving_v;
    logic [1:0]      ack_v;
    logic            cur_lane;
    logic            req_cur;
    logic            req_oth;
    logic            ack_cur;
    logic [7:0]      data_cur;

    assign req_v        = {req1, req0};
    assign serving_v[0] = (state_q == ST_SERVE0);
    assign serving_v[1] = (state_q == ST_SERVE1);

    // A lane is consumed only by its owner; reset masks acks before the state clears.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_v[gi] = !reset && serving_v[gi] && req_v[gi];
        end
    endgenerate

    assign ack0     = ack_v[0];
    assign ack1     = ack_v[1];
    assign cur_lane = serving_v[1];
    assign req_cur  = req_v[cur_lane];
    assign req_oth  = req_v[!cur_lane];
    assign ack_cur  = |ack_v;
    assign data_cur = cur_lane ? data1 : data0;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            sync_cnt_q  <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            data_out_q  <= IDLE_SYM;
            valid_out_q <= 1'b0;
            grant_q     <= 2'b00;
            sync_done_q <= 1'b0;
        end else begin
            data_out_q  <= IDLE_SYM;
            valid_out_q <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_q     <= ST_IDLE;
                        sync_done_q <= 1'b1;
                    end else begin
                        sync_cnt_q <= sync_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= ST_SERVE0;
                        grant_q <= 2'b01;
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (req1) begin
                        state_q <= ST_SERVE1;
                        grant_q <= 2'b10;
                        last_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (ack_cur) begin
                        data_out_q  <= data_cur;
                        valid_out_q <= 1'b1;
                    end
                    if (ack_cur && (cnt_q != CNT_LAST)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Burst over: full burst or owner went quiet (req_cur low).
                        cnt_q <= '0;
                        if (req_oth) begin
                            state_q <= cur_lane ? ST_SERVE0 : ST_SERVE1;
                            grant_q <= cur_lane ? 2'b01 : 2'b10;
                            last_q  <= !cur_lane;
                        end else if (!ack_cur || !req_cur) begin
                            state_q <= ST_IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign grant     = grant_q;
    assign sync_done = sync_done_q;

endmodule
